// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing stage.
//   alu_op_e    : ALU control encoding (ADD/SUB/AND/OR)
//   seq_state_e : sequencer FSM states
//   instr_t     : 8-bit register-to-register instruction layout
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 4;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_e;

  typedef struct packed {
    alu_op_e    op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer.
//   clk, rst            : clock, synchronous active-high reset (clears all entries)
//   we_i/waddr_i/wdata_i: single synchronous write port
//   raddr_a_i/rdata_a_o : combinational read port A (rs1)
//   raddr_b_i/rdata_b_o : combinational read port B (rs2)
//   dbg_addr_i/dbg_data_o: combinational debug read port
module alu_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [1:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [1:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer feeding an external 8-bit two-operand ALU.
//   clk, rst                 : clock, synchronous active-high reset
//   instr_valid/instr_ready  : instruction handshake, instr = {op, rd, rs1, rs2}
//   ld_valid/ld_addr/ld_data : direct register load (IDLE only, beats instructions)
//   alu_a/alu_b/alu_ctrl     : registered operands/control to the ALU
//   alu_result/zero/overflow : combinational ALU outputs, consumed in EXEC
//   done_*                   : one-cycle completion pulse plus held rd/data
//   flag_zero/flag_ovf       : flags of the last completed instruction
//   ovf_sticky/clr_sticky    : accumulated overflow and its clear
//   busy                     : high while in EXEC
//   dbg_addr/dbg_data        : combinational register file peek
module alu_seq_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic              ld_valid,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              done_valid,
  output logic [1:0]        done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              flag_zero,
  output logic              flag_ovf,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output logic              busy,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_pkg::*;

  instr_t            instr_s;
  seq_state_e        state_q, state_d;
  logic              accept;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] alu_a_q, alu_b_q, done_data_q;
  alu_op_e           alu_ctrl_q;
  logic [1:0]        done_rd_q;
  logic              done_valid_q, flag_zero_q, flag_ovf_q, ovf_sticky_q;

  assign instr_s = instr_t'(instr);

  alu_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (instr_s.rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (instr_s.rs2),
    .rdata_b_o (rs2_data),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  // Write port is shared: EXEC write-back, otherwise an IDLE load.
  // A pending load wins over an instruction by holding instr_ready low.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;
    unique case (state_q)
      IDLE: begin
        instr_ready = ~ld_valid & ~rst;
        if (ld_valid) begin
          rf_we = 1'b1;
        end else if (instr_valid && !rst) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = alu_result;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = instr_ready & instr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ADD;
      rd_q         <= '0;
      done_valid_q <= 1'b0;
      done_rd_q    <= '0;
      done_data_q  <= '0;
      flag_zero_q  <= 1'b0;
      flag_ovf_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      done_valid_q <= (state_q == EXEC);
      if (accept) begin
        alu_a_q    <= rs1_data;
        alu_b_q    <= rs2_data;
        alu_ctrl_q <= instr_s.op;
        rd_q       <= instr_s.rd;
      end
      if (state_q == EXEC) begin
        done_rd_q   <= rd_q;
        done_data_q <= alu_result;
        flag_zero_q <= alu_zero;
        flag_ovf_q  <= alu_overflow;
      end
      // A completing overflow outranks a same-cycle clear.
      if ((state_q == EXEC) && alu_overflow) begin
        ovf_sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky_q <= 1'b0;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign done_valid = done_valid_q;
  assign done_rd    = done_rd_q;
  assign done_data  = done_data_q;
  assign flag_zero  = flag_zero_q;
  assign flag_ovf   = flag_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign busy       = (state_q == EXEC);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU attached.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, instr_valid, instr_ready, ld_valid, clr_sticky;
  logic [7:0] instr, ld_data, alu_a, alu_b, alu_result, done_data, dbg_data;
  logic [1:0] ld_addr, alu_ctrl, done_rd, dbg_addr;
  logic       alu_zero, alu_overflow, done_valid, flag_zero, flag_ovf, ovf_sticky, busy;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .done_valid(done_valid),
    .done_rd(done_rd), .done_data(done_data), .flag_zero(flag_zero),
    .flag_ovf(flag_ovf), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Attached ALU: overflow is carry-out for ADD, borrow for SUB.
  logic [8:0] alu_w;
  always_comb begin
    alu_w        = '0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      2'b00: begin
        alu_w        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_w[7:0];
        alu_overflow = alu_w[8];
      end
      2'b01: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a < alu_b);
      end
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  typedef struct {
    int rd;
    int data;
    bit zero;
    bit ovf;
    int cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         mregs[4];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         prev_dv = 1'b0;
  logic       mon_sel = 1'b0;
  logic [1:0] mon_addr = '0;
  logic [1:0] drv_addr = '0;

  assign dbg_addr = mon_sel ? mon_addr : drv_addr;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output bit ovf);
    ovf = 1'b0;
    case (op)
      0: begin r = a + b; ovf = (r > 255); r = r % 256; end
      1: begin ovf = (a < b); r = a - b; if (r < 0) r += 256; end
      2: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic issue(input logic [7:0] ins, input bit commit);
    int   op, rd, s1, s2, r, ea, eb, tries;
    bit   ovf;
    exp_t e;
    op = int'(ins[7:6]); rd = int'(ins[5:4]); s1 = int'(ins[3:2]); s2 = int'(ins[1:0]);
    instr = ins;
    instr_valid = 1'b1;
    tries = 0;
    #1;
    while (!instr_ready && tries < 10) begin
      @(negedge clk); #1; tries++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    ea = mregs[s1];
    eb = mregs[s2];
    ref_alu(op, ea, eb, r, ovf);
    if (commit) begin
      e = '{rd, r, (r == 0), ovf, cyc};
      sb_q.push_back(e);
      mregs[rd] = r;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(op));
    chk("busy_exec", 32'(busy), 32'd1);
  endtask

  task automatic load(input int a, input int d);
    int tries = 0;
    while (busy && tries < 10) begin
      @(negedge clk); tries++;
    end
    ld_addr  = 2'(a);
    ld_data  = 8'(d);
    ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    mregs[a] = d;
  endtask

  task automatic check_reg(input int a, input int exp_v, input string name);
    #3;
    drv_addr = 2'(a);
    #1;
    chk(name, 32'(dbg_data), 32'(exp_v));
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (done_valid) begin
      chk("done_pulse_len", 32'(prev_dv), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_rd", 32'(done_rd), 32'(mon_e.rd));
        chk("done_data", 32'(done_data), 32'(mon_e.data));
        chk("flag_zero", 32'(flag_zero), 32'(mon_e.zero));
        chk("flag_ovf", 32'(flag_ovf), 32'(mon_e.ovf));
        chk("done_latency", 32'(cyc), 32'(mon_e.cyc + 2));
        mon_addr = 2'(mon_e.rd);
        mon_sel  = 1'b1;
        #1;
        chk("rf_writeback", 32'(dbg_data), 32'(mon_e.data));
        mon_sel = 1'b0;
      end
    end
    prev_dv = done_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; clr_sticky = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_gated", 32'(instr_ready), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(instr_ready), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_reg(i, 0, "rst_reg");

    // ADD r3,r1,r2 with carry out
    load(1, 8'h0F);
    load(2, 8'hF1);
    issue(8'h36, 1'b1);
    @(negedge clk);
    chk("sticky_after_add", 32'(ovf_sticky), 32'd1);
    // SUB r0,r1,r1
    issue(8'h45, 1'b1);
    @(negedge clk);

    // Back-to-back OR then AND reading the fresh r3
    load(1, 8'h3C);
    load(2, 8'h0F);
    issue(8'hF6, 1'b1);
    issue(8'hB7, 1'b1);
    repeat (2) @(negedge clk);
    check_reg(3, 8'h3C, "b2b_r3");

    // Load and instruction offered together: load wins
    ld_addr = 2'd2; ld_data = 8'hAA; ld_valid = 1'b1;
    instr = 8'h9A; instr_valid = 1'b1;
    #1;
    chk("ld_beats_instr", 32'(instr_ready), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    mregs[2] = 8'hAA;
    issue(8'h9A, 1'b1);
    repeat (2) @(negedge clk);

    // Reset while in EXEC aborts the instruction
    issue(8'h36, 1'b0);
    rst = 1'b1;
    #1;
    chk("exec_rst_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    chk("abort_done_valid", 32'(done_valid), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_alu_b", 32'(alu_b), 32'd0);
    chk("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("abort_done_rd", 32'(done_rd), 32'd0);
    chk("abort_done_data", 32'(done_data), 32'd0);
    chk("abort_flags", 32'({flag_zero, flag_ovf, ovf_sticky, busy}), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check_reg(3, 0, "abort_no_write");

    // Set beats clear on the same edge; a lone clear then clears
    chk("sticky_pre", 32'(ovf_sticky), 32'd0);
    load(1, 8'hFF);
    load(2, 8'h01);
    issue(8'h36, 1'b1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_cleared", 32'(ovf_sticky), 32'd0);

    // Randomized mix of loads and instructions
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        load(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      else
        issue(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) check_reg(i, mregs[i], "final_reg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
